hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS core. It drives the ID_EX_enable input of the ID/EX pipeline register, plus the PC and IF/ID hold and flush controls.
- Detects load-use hazards, waits on the data-memory handshake, and flushes after taken branches.
- Its registered outputs update on the rising edge of clk. The pipeline registers capture on the falling edge, so the controls are stable half a cycle before use.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/load_use_detect.sv | 35 +++
 rtl/hazard_stall_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage MIPS core's hazard/stall control.
//   state_t        : hazard controller state encoding
//   REG_ZERO       : architectural register $0, which is never a real dependency
//   STALL_CNT_MAX  : saturation value of the stall cycle counter
// -----------------------------------------------------------------------------
package pipeline_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_LOAD  = 2'd1,
      ST_MEMW  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam logic [4:0] REG_ZERO      = 5'd0;
   localparam logic [7:0] STALL_CNT_MAX = 8'd255;

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use comparator. Flags when the load currently in
// EX writes a register that the instruction in IF/ID reads.
// Ports:
//   i_id_ex_mem_rd  : ID/EX holds a load
//   i_id_ex_rt      : load destination register
//   i_if_id_rs      : rs of the IF/ID instruction
//   i_if_id_rt      : rt of the IF/ID instruction
//   i_if_id_uses_rt : IF/ID instruction actually reads rt
//   o_load_use      : hazard present
// -----------------------------------------------------------------------------
module load_use_detect
   import pipeline_pkg::*;
(
   input  logic       i_id_ex_mem_rd,
   input  logic [4:0] i_id_ex_rt,
   input  logic [4:0] i_if_id_rs,
   input  logic [4:0] i_if_id_rt,
   input  logic       i_if_id_uses_rt,
   output logic       o_load_use
);

   logic w_rs_match;
   logic w_rt_match;

   assign w_rs_match = (i_id_ex_rt == i_if_id_rs);
   assign w_rt_match = i_if_id_uses_rt && (i_id_ex_rt == i_if_id_rt);

   // A load into $0 is discarded by the register file, so it cannot create
   // a dependency even when the register numbers match.
   assign o_load_use = i_id_ex_mem_rd && (i_id_ex_rt != REG_ZERO) &&
                       (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline hazard and stall controller. Outputs are registered on the rising
// edge; the pipeline registers capture on the falling edge.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   if_id_rs/rt, if_id_uses_rt : source operands of the IF/ID instruction
//   id_ex_mem_rd, id_ex_rt     : load in EX and its destination
//   ex_mem_req, mem_ready      : data-memory handshake from MEM
//   branch_taken               : branch resolved taken this cycle
//   pc_hold, if_id_hold        : hold PC / IF/ID
//   if_id_flush                : IF/ID loads a NOP
//   ID_EX_enable               : 1 = ID/EX takes a bubble
//   pipe_freeze                : ID/EX, EX/MEM, MEM/WB hold
//   mem_timeout_err            : sticky memory-wait timeout
//   stall_count                : saturating count of non-RUN cycles
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT  = 15,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] if_id_rs,
   input  logic [4:0] if_id_rt,
   input  logic       if_id_uses_rt,
   input  logic       id_ex_mem_rd,
   input  logic [4:0] id_ex_rt,
   input  logic       ex_mem_req,
   input  logic       mem_ready,
   input  logic       branch_taken,
   output logic       pc_hold,
   output logic       if_id_hold,
   output logic       if_id_flush,
   output logic       ID_EX_enable,
   output logic       pipe_freeze,
   output logic       mem_timeout_err,
   output logic [7:0] stall_count
);

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);
   localparam logic [1:0] FLUSH_LIMIT   = 2'(FLUSH_CYCLES);

   state_t     r_state,          w_state_nxt;
   logic [7:0] r_wait_cnt,       w_wait_cnt_nxt;
   logic [1:0] r_flush_cnt,      w_flush_cnt_nxt;
   logic       r_branch_pending, w_branch_pending_nxt;
   logic       r_err,            w_err_nxt;
   logic       r_pc_hold,        w_pc_hold_nxt;
   logic       r_if_id_hold,     w_if_id_hold_nxt;
   logic       r_if_id_flush,    w_if_id_flush_nxt;
   logic       r_id_ex_bubble,   w_id_ex_bubble_nxt;
   logic       r_freeze,         w_freeze_nxt;
   logic [7:0] r_stall_cnt;

   logic w_load_use;
   logic w_mem_stall;

   load_use_detect u_load_use_detect (
      .i_id_ex_mem_rd  (id_ex_mem_rd),
      .i_id_ex_rt      (id_ex_rt),
      .i_if_id_rs      (if_id_rs),
      .i_if_id_rt      (if_id_rt),
      .i_if_id_uses_rt (if_id_uses_rt),
      .o_load_use      (w_load_use)
   );

   assign w_mem_stall = ex_mem_req && !mem_ready;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned; otherwise synthesis infers a latch.
      w_state_nxt          = r_state;
      w_wait_cnt_nxt       = r_wait_cnt;
      w_flush_cnt_nxt      = r_flush_cnt;
      w_branch_pending_nxt = r_branch_pending;
      w_err_nxt            = r_err;
      w_pc_hold_nxt        = 1'b0;
      w_if_id_hold_nxt     = 1'b0;
      w_if_id_flush_nxt    = 1'b0;
      w_id_ex_bubble_nxt   = 1'b0;
      w_freeze_nxt         = 1'b0;

      unique case (r_state)
         ST_RUN: begin
            if (w_mem_stall) begin
               w_state_nxt      = ST_MEMW;
               w_pc_hold_nxt    = 1'b1;
               w_if_id_hold_nxt = 1'b1;
               w_freeze_nxt     = 1'b1;
               w_wait_cnt_nxt   = 8'd1;
               // The branch is remembered and its flush replayed once the
               // memory access completes.
               if (branch_taken) w_branch_pending_nxt = 1'b1;
            end else if (branch_taken) begin
               // Any load-use partner is in the discarded shadow of the branch.
               w_state_nxt        = ST_FLUSH;
               w_if_id_flush_nxt  = 1'b1;
               w_id_ex_bubble_nxt = 1'b1;
               w_flush_cnt_nxt    = 2'd1;
            end else if (w_load_use) begin
               w_state_nxt        = ST_LOAD;
               w_pc_hold_nxt      = 1'b1;
               w_if_id_hold_nxt   = 1'b1;
               w_id_ex_bubble_nxt = 1'b1;
            end
         end

         // The load has moved on to MEM, so a single bubble resolves it.
         ST_LOAD: w_state_nxt = ST_RUN;

         ST_MEMW: begin
            if (mem_ready) begin
               if (r_branch_pending) begin
                  w_state_nxt          = ST_FLUSH;
                  w_branch_pending_nxt = 1'b0;
                  w_if_id_flush_nxt    = 1'b1;
                  w_id_ex_bubble_nxt   = 1'b1;
                  w_flush_cnt_nxt      = 2'd1;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end else if (r_wait_cnt == TIMEOUT_LIMIT) begin
               // Abandon the access; a stale pending branch must not fire later.
               w_state_nxt          = ST_RUN;
               w_err_nxt            = 1'b1;
               w_branch_pending_nxt = 1'b0;
            end else begin
               w_wait_cnt_nxt   = r_wait_cnt + 8'd1;
               w_pc_hold_nxt    = 1'b1;
               w_if_id_hold_nxt = 1'b1;
               w_freeze_nxt     = 1'b1;
            end
         end

         ST_FLUSH: begin
            if (w_mem_stall) begin
               // Freeze takes over; the flush restarts once memory is ready.
               w_state_nxt          = ST_MEMW;
               w_branch_pending_nxt = 1'b1;
               w_flush_cnt_nxt      = 2'd1;
               w_wait_cnt_nxt       = 8'd1;
               w_pc_hold_nxt        = 1'b1;
               w_if_id_hold_nxt     = 1'b1;
               w_freeze_nxt         = 1'b1;
            end else if (r_flush_cnt < FLUSH_LIMIT) begin
               w_flush_cnt_nxt    = r_flush_cnt + 2'd1;
               w_if_id_flush_nxt  = 1'b1;
               w_id_ex_bubble_nxt = 1'b1;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end

         default: w_state_nxt = ST_RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state          <= ST_RUN;
         r_wait_cnt       <= 8'd0;
         r_flush_cnt      <= 2'd0;
         r_branch_pending <= 1'b0;
         r_err            <= 1'b0;
         r_pc_hold        <= 1'b0;
         r_if_id_hold     <= 1'b0;
         r_if_id_flush    <= 1'b0;
         r_id_ex_bubble   <= 1'b0;
         r_freeze         <= 1'b0;
         r_stall_cnt      <= 8'd0;
      end else begin
         r_state          <= w_state_nxt;
         r_wait_cnt       <= w_wait_cnt_nxt;
         r_flush_cnt      <= w_flush_cnt_nxt;
         r_branch_pending <= w_branch_pending_nxt;
         r_err            <= w_err_nxt;
         r_pc_hold        <= w_pc_hold_nxt;
         r_if_id_hold     <= w_if_id_hold_nxt;
         r_if_id_flush    <= w_if_id_flush_nxt;
         r_id_ex_bubble   <= w_id_ex_bubble_nxt;
         r_freeze         <= w_freeze_nxt;
         if ((r_state != ST_RUN) && (r_stall_cnt != STALL_CNT_MAX))
            r_stall_cnt <= r_stall_cnt + 8'd1;
      end
   end

   assign pc_hold         = r_pc_hold;
   assign if_id_hold      = r_if_id_hold;
   assign if_id_flush     = r_if_id_flush;
   assign ID_EX_enable    = r_id_ex_bubble;
   assign pipe_freeze     = r_freeze;
   assign mem_timeout_err = r_err;
   assign stall_count     = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed bench for hazard_stall_ctrl (MEM_TIMEOUT=15, FLUSH_CYCLES=2).
// Each step drives inputs, queues the expected post-edge outputs, clocks once
// and compares what the DUT shows 1 time unit after the rising edge.
// Control vector order: {pc_hold, if_id_hold, if_id_flush, ID_EX_enable,
// pipe_freeze}.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

   localparam logic [4:0] C_NONE   = 5'b00000;
   localparam logic [4:0] C_LOAD   = 5'b11010;
   localparam logic [4:0] C_FLUSH  = 5'b00110;
   localparam logic [4:0] C_FREEZE = 5'b11001;

   typedef struct {
      string      tag;
      logic [4:0] ctl;
      logic       err;
      int         cnt;   // negative: count not checked on this step
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [4:0] if_id_rs;
   logic [4:0] if_id_rt;
   logic       if_id_uses_rt;
   logic       id_ex_mem_rd;
   logic [4:0] id_ex_rt;
   logic       ex_mem_req;
   logic       mem_ready;
   logic       branch_taken;
   logic       pc_hold;
   logic       if_id_hold;
   logic       if_id_flush;
   logic       ID_EX_enable;
   logic       pipe_freeze;
   logic       mem_timeout_err;
   logic [7:0] stall_count;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   hazard_stall_ctrl #(
      .MEM_TIMEOUT  (15),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .if_id_rs        (if_id_rs),
      .if_id_rt        (if_id_rt),
      .if_id_uses_rt   (if_id_uses_rt),
      .id_ex_mem_rd    (id_ex_mem_rd),
      .id_ex_rt        (id_ex_rt),
      .ex_mem_req      (ex_mem_req),
      .mem_ready       (mem_ready),
      .branch_taken    (branch_taken),
      .pc_hold         (pc_hold),
      .if_id_hold      (if_id_hold),
      .if_id_flush     (if_id_flush),
      .ID_EX_enable    (ID_EX_enable),
      .pipe_freeze     (pipe_freeze),
      .mem_timeout_err (mem_timeout_err),
      .stall_count     (stall_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drv(input logic mrd, input logic [4:0] xrt,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic req, input logic rdy,
                      input logic br);
      id_ex_mem_rd  = mrd;
      id_ex_rt      = xrt;
      if_id_rs      = rs;
      if_id_rt      = rt;
      if_id_uses_rt = urt;
      ex_mem_req    = req;
      mem_ready     = rdy;
      branch_taken  = br;
   endtask

   task automatic idle();
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Clock once without checking anything.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag, input logic [4:0] ctl,
                      input logic err, input int cnt);
      exp_t e;
      logic [4:0] obs;
      sb.push_back('{tag: tag, ctl: ctl, err: err, cnt: cnt});
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = {pc_hold, if_id_hold, if_id_flush, ID_EX_enable, pipe_freeze};
      n_cmp++;
      assert (obs === e.ctl) else begin
         n_fail++;
         $error("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
      end
      n_cmp++;
      assert (mem_timeout_err === e.err) else begin
         n_fail++;
         $error("FAIL %s err: got %b expected %b", e.tag, mem_timeout_err, e.err);
      end
      if (e.cnt >= 0) begin
         n_cmp++;
         assert (stall_count === 8'(e.cnt)) else begin
            n_fail++;
            $error("FAIL %s stall_count: got %0d expected %0d", e.tag, stall_count, e.cnt);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      cyc("reset", C_NONE, 1'b0, 0);
      rst_n = 1'b1;

      // Load-use on rs: one bubble cycle then back to RUN.
      drv(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("lu_rs_enter", C_LOAD, 1'b0, 0);
      idle();
      cyc("lu_rs_exit", C_NONE, 1'b0, 1);

      // Load-use on rt with uses_rt set.
      drv(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("lu_rt_enter", C_LOAD, 1'b0, 1);
      idle();
      cyc("lu_rt_exit", C_NONE, 1'b0, 2);

      // rt matches but the instruction does not read rt.
      drv(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("lu_rt_unused", C_NONE, 1'b0, 2);

      // Load into $0 is never a hazard.
      drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("lu_reg_zero", C_NONE, 1'b0, 2);

      // Register match without a load.
      drv(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("no_load", C_NONE, 1'b0, 2);

      // Memory wait of three cycles, counted from a fresh reset.
      rst_n = 1'b0;
      idle();
      cyc("reset2", C_NONE, 1'b0, 0);
      rst_n = 1'b1;
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("memw_1", C_FREEZE, 1'b0, 0);
      cyc("memw_2", C_FREEZE, 1'b0, 1);
      cyc("memw_3", C_FREEZE, 1'b0, 2);
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("memw_done", C_NONE, 1'b0, 3);
      cyc("mem_ready_no_stall", C_NONE, 1'b0, 3);

      // Memory never ready: 15 frozen cycles then timeout.
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) cyc("timeout_wait", C_FREEZE, 1'b0, 3 + i);
      cyc("timeout_fire", C_NONE, 1'b1, 18);
      idle();
      cyc("err_sticky_1", C_NONE, 1'b1, 18);
      cyc("err_sticky_2", C_NONE, 1'b1, 18);
      rst_n = 1'b0;
      cyc("err_reset", C_NONE, 1'b0, 0);
      rst_n = 1'b1;

      // Branch and load-use together: branch wins, two flush cycles.
      drv(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc("br_lu_flush_1", C_FLUSH, 1'b0, 0);
      idle();
      cyc("br_lu_flush_2", C_FLUSH, 1'b0, 1);
      cyc("br_lu_exit", C_NONE, 1'b0, 2);
      cyc("br_lu_idle", C_NONE, 1'b0, 2);

      // Branch during memory stall: freeze first, flush after mem_ready.
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc("br_mem_freeze_1", C_FREEZE, 1'b0, 2);
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("br_mem_freeze_2", C_FREEZE, 1'b0, 3);
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("br_mem_flush_1", C_FLUSH, 1'b0, 4);
      idle();
      cyc("br_mem_flush_2", C_FLUSH, 1'b0, 5);
      cyc("br_mem_exit", C_NONE, 1'b0, 6);

      // Memory stall preempting a flush; flush restarts afterwards.
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc("pre_flush", C_FLUSH, 1'b0, 6);
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("pre_freeze", C_FREEZE, 1'b0, 7);
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("pre_reflush_1", C_FLUSH, 1'b0, 8);
      idle();
      cyc("pre_reflush_2", C_FLUSH, 1'b0, 9);
      cyc("pre_exit", C_NONE, 1'b0, 10);

      // Reset mid-wait drops the pending branch.
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc("rst_mid_freeze_1", C_FREEZE, 1'b0, 10);
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("rst_mid_freeze_2", C_FREEZE, 1'b0, 11);
      rst_n = 1'b0;
      cyc("rst_mid_apply", C_NONE, 1'b0, 0);
      rst_n = 1'b1;
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("rst_mid_no_flush_1", C_NONE, 1'b0, 0);
      cyc("rst_mid_no_flush_2", C_NONE, 1'b0, 0);

      // Repeated timeouts push the stall counter into saturation.
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) tick();
      drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      idle();
      cyc("stall_saturate", C_NONE, 1'b1, 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
